ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage, directly downstream of instruction decode. Consumes decoded alu_op/alu_sel/operands/
//  write target and computes logic, shift or iterative 32-cycle divide results. Registers results into
//  the EX/MEM latch. Drives the ex_rewrite_* forwarding bus back to decode and raises stall_req while a
//  divide is in flight.
// PARAMETERS
//  DIV_CYCLES  32  iterations of radix-2 restoring divider (fixed 32 for 32-bit operands)
// PORTS
//  clk              in   1   stage clock, rising edge
//  reset            in   1   asynchronous, active-high
//  flush            in   1   cancel in-flight instruction (divide included), latch a bubble
//  alu_op           in   8   operation code from decode
//  alu_sel          in   3   result class: 000 nop, 001 logic, 010 shift, 011 divide
//  src_data1        in   32  operand 1 (rs or immediate/shamt)
//  src_data2        in   32  operand 2 (rt or immediate)
//  wr_addr          in   5   destination register
//  wr_en            in   1   destination write enable
//  ex_rewrite_en    out  1   forwarding valid to decode (combinational)
//  ex_rewrite_addr  out  5   forwarding address (combinational)
//  ex_rewrite_data  out  32  forwarding data (combinational)
//  stall_req        out  1   hold PC/IF/ID; decode inputs must stay stable while high
//  mem_wr_en        out  1   EX/MEM latch: write enable
//  mem_wr_addr      out  5   EX/MEM latch: destination
//  mem_wr_data      out  32  EX/MEM latch: result
//  mem_hilo_en      out  1   EX/MEM latch: HI/LO write enable
//  mem_hi           out  32  EX/MEM latch: remainder
//  mem_lo           out  32  EX/MEM latch: quotient
// BEHAVIOUR
//  Reset (async): all mem_* = 0, stall_req = 0, FSM = IDLE, divider regs = 0.
//  Logic (sel 001): 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR of src1,src2. Unknown op -> 0.
//  Shift (sel 010): 0x7C SLL src2<<src1[4:0]; 0x02 SRL logical >>; 0x03 SRA arithmetic >>. Bits src1[31:5] ignored.
//  Divide (sel 011): 0x1A DIV signed, 0x1B DIVU unsigned; result only to HI/LO, mem_wr_en = 0.
//  nop (sel 000) or unknown sel: result 0, mem_wr_en follows wr_en (PREF/SYNC pass through harmlessly).
//  Latency: logic/shift 1 cycle (combinational compute, latched at next edge); forwarding bus is the
//   pre-latch value, ex_rewrite_en = wr_en & ~stall_req & ~flush.
//  Divider FSM: IDLE -> (sel 011, no flush) -> if src2==0 go DONE directly, else BUSY.
//   BUSY: one quotient bit per cycle, counter 0..31; at count 31 -> DONE. DONE -> IDLE.
//   stall_req = 1 combinationally in IDLE when sel==011 and in BUSY; 0 in DONE.
//   Total: divide enters at edge N, result in EX/MEM after 34 edges (32 BUSY + DONE + latch).
//  Signed: divide |src1| by |src2|; quotient negated if signs differ, remainder takes dividend sign.
//   0x80000000 / -1 -> lo 0x80000000, hi 0 (wraps, no trap).
//  Divide by zero: 1-cycle DONE, lo = 0xFFFFFFFF, hi = src1.
//  While stall_req = 1, EX/MEM latches a bubble (all mem_* enables 0, data 0).
//  DONE cycle: mem_hilo_en = 1 with hi/lo at next edge.
//  flush: highest priority; next edge FSM -> IDLE, counter cleared, bubble latched, stall_req drops the
//   same cycle.
//  Async reset mid-divide: abandons operation, no HI/LO write ever issued.
//  Back-to-back divides: second one starts from IDLE on the cycle after DONE.
// TESTING
//  OR src1=0x0000F0F0 src2=0x00000F0F wr_addr=3 -> forward 0xFFFF same cycle; mem_wr_data=0xFFFF, addr 3 next edge.
//  SRA src1=4 src2=0x80000000 -> 0xF8000000; SLL src1=0x25 src2=1 -> 0x20 (only [4:0] used).
//  DIVU 100/7 -> stall_req high 33 cycles, then mem_hilo_en=1, lo=14, hi=2, mem_wr_en=0.
//  DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  DIVU 5/0 -> stall 1 cycle, lo=0xFFFFFFFF, hi=5.
//  flush at BUSY count 10 -> stall_req low same cycle, no hilo write; reset asserted mid-divide -> all outputs 0 immediately.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: logic/shift in one cycle, 32-iteration restoring divide into HI/LO, EX/MEM latch.
// Latency 1 cycle for logic/shift, 34 edges for divide; stall_req holds upstream while a divide runs.
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [7:0]  alu_op,
  input  logic [2:0]  alu_sel,
  input  logic [31:0] src_data1,
  input  logic [31:0] src_data2,
  input  logic [4:0]  wr_addr,
  input  logic        wr_en,
  output logic        ex_rewrite_en,
  output logic [4:0]  ex_rewrite_addr,
  output logic [31:0] ex_rewrite_data,
  output logic        stall_req,
  output logic        mem_wr_en,
  output logic [4:0]  mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_hilo_en,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [4:0] CNT_LAST = 5'(DIV_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic        negq_q, negq_d, negr_q, negr_d;

  logic        is_div, div_signed;
  logic [31:0] result, a_abs, b_abs;
  logic [32:0] shifted;
  logic        ge;

  assign is_div     = (alu_sel == 3'b011);
  assign div_signed = (alu_op == 8'h1A);
  assign a_abs      = (div_signed && src_data1[31]) ? -src_data1 : src_data1;
  assign b_abs      = (div_signed && src_data2[31]) ? -src_data2 : src_data2;

  // Trial subtraction of one restoring-divide step.
  assign shifted = {rem_q, quo_q[31]};
  assign ge      = (shifted >= {1'b0, dvs_q});

  always_comb begin
    result = 32'h0;
    case (alu_sel)
      3'b001: begin
        case (alu_op)
          8'h24:   result = src_data1 & src_data2;
          8'h25:   result = src_data1 | src_data2;
          8'h26:   result = src_data1 ^ src_data2;
          8'h27:   result = ~(src_data1 | src_data2);
          default: result = 32'h0;
        endcase
      end
      3'b010: begin
        case (alu_op)
          8'h7C:   result = src_data2 << src_data1[4:0];
          8'h02:   result = src_data2 >> src_data1[4:0];
          8'h03:   result = $unsigned($signed(src_data2) >>> src_data1[4:0]);
          default: result = 32'h0;
        endcase
      end
      default: result = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_div) begin
            cnt_d = 5'd0;
            if (src_data2 == 32'h0) begin
              state_d = S_DONE;
              quo_d   = 32'hFFFF_FFFF;
              rem_d   = src_data1;
              negq_d  = 1'b0;
              negr_d  = 1'b0;
            end else begin
              state_d = S_BUSY;
              quo_d   = a_abs;
              rem_d   = 32'h0;
              dvs_d   = b_abs;
              negq_d  = div_signed & (src_data1[31] ^ src_data2[31]);
              negr_d  = div_signed & src_data1[31];
            end
          end
        end
        S_BUSY: begin
          quo_d = {quo_q[30:0], ge};
          rem_d = ge ? 32'(shifted - {1'b0, dvs_q}) : shifted[31:0];
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == CNT_LAST) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Reset gating keeps stall low even while decode still presents a divide.
  assign stall_req = ~reset & ~flush &
                     (((state_q == S_IDLE) & is_div) | (state_q == S_BUSY));

  assign ex_rewrite_en   = wr_en & ~stall_req & ~flush;
  assign ex_rewrite_addr = wr_addr;
  assign ex_rewrite_data = result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      quo_q       <= 32'h0;
      rem_q       <= 32'h0;
      dvs_q       <= 32'h0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= 5'd0;
      mem_wr_data <= 32'h0;
      mem_hilo_en <= 1'b0;
      mem_hi      <= 32'h0;
      mem_lo      <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      if (flush || stall_req) begin
        mem_wr_en   <= 1'b0;
        mem_wr_addr <= 5'd0;
        mem_wr_data <= 32'h0;
        mem_hilo_en <= 1'b0;
        mem_hi      <= 32'h0;
        mem_lo      <= 32'h0;
      end else begin
        mem_wr_en   <= wr_en & ~is_div;
        mem_wr_addr <= wr_addr;
        mem_wr_data <= result;
        mem_hilo_en <= (state_q == S_DONE);
        mem_hi      <= (state_q == S_DONE) ? (negr_q ? -rem_q : rem_q) : 32'h0;
        mem_lo      <= (state_q == S_DONE) ? (negq_q ? -quo_q : quo_q) : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: logic, shift, divide timing/results, flush and reset abort.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset, flush, wr_en;
  logic [7:0]  alu_op;
  logic [2:0]  alu_sel;
  logic [31:0] src_data1, src_data2;
  logic [4:0]  wr_addr;
  logic        ex_rewrite_en, stall_req, mem_wr_en, mem_hilo_en;
  logic [4:0]  ex_rewrite_addr, mem_wr_addr;
  logic [31:0] ex_rewrite_data, mem_wr_data, mem_hi, mem_lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .alu_op(alu_op), .alu_sel(alu_sel),
    .src_data1(src_data1), .src_data2(src_data2), .wr_addr(wr_addr), .wr_en(wr_en),
    .ex_rewrite_en(ex_rewrite_en), .ex_rewrite_addr(ex_rewrite_addr),
    .ex_rewrite_data(ex_rewrite_data), .stall_req(stall_req),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_hilo_en(mem_hilo_en), .mem_hi(mem_hi), .mem_lo(mem_lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] addr, input logic we);
    alu_sel = sel; alu_op = op; src_data1 = a; src_data2 = b; wr_addr = addr; wr_en = we;
  endtask

  task automatic nop();
    drive(3'b000, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic alu(input string tag, input logic [2:0] sel, input logic [7:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    drive(sel, op, a, b, 5'd7, 1'b1);
    #1;
    chk({tag, "_fwd"}, ex_rewrite_data, exp);
    tick();
    chk({tag, "_mem"}, mem_wr_data, exp);
  endtask

  // Runs one divide: checks stall length, then the HI/LO latch after DONE.
  task automatic do_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stall,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n = 0;
    drive(3'b011, op, a, b, 5'd9, 1'b0);
    #1;
    while (stall_req === 1'b1 && n < 100) begin
      n++;
      tick();
      if (n == 1) chk({tag, "_bubble_hilo"}, {31'd0, mem_hilo_en}, 32'd0);
    end
    chk({tag, "_stall_cycles"}, n, exp_stall);
    nop();
    tick();
    chk({tag, "_hilo_en"}, {31'd0, mem_hilo_en}, 32'd1);
    chk({tag, "_lo"}, mem_lo, exp_lo);
    chk({tag, "_hi"}, mem_hi, exp_hi);
    chk({tag, "_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
  endtask

  initial begin
    int hilo_seen;
    reset = 1'b1; flush = 1'b0;
    nop();
    #12;
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_hilo", {31'd0, mem_hilo_en}, 32'd0);
    chk("rst_data", mem_wr_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // OR with forwarding checked in the same cycle
    drive(3'b001, 8'h25, 32'h0000F0F0, 32'h00000F0F, 5'd3, 1'b1);
    #1;
    chk("or_fwd_en", {31'd0, ex_rewrite_en}, 32'd1);
    chk("or_fwd_addr", {27'd0, ex_rewrite_addr}, 32'd3);
    chk("or_fwd_data", ex_rewrite_data, 32'h0000FFFF);
    tick();
    chk("or_mem_data", mem_wr_data, 32'h0000FFFF);
    chk("or_mem_addr", {27'd0, mem_wr_addr}, 32'd3);
    chk("or_mem_en", {31'd0, mem_wr_en}, 32'd1);

    alu("and", 3'b001, 8'h24, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00);
    alu("xor", 3'b001, 8'h26, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0);
    alu("nor", 3'b001, 8'h27, 32'h0000F0F0, 32'h00000F0F, 32'hFFFF0000);
    alu("logic_bad_op", 3'b001, 8'h55, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    alu("sra", 3'b010, 8'h03, 32'h4, 32'h80000000, 32'hF8000000);
    alu("srl", 3'b010, 8'h02, 32'h4, 32'h80000000, 32'h08000000);
    alu("sll", 3'b010, 8'h7C, 32'h25, 32'h1, 32'h20);

    drive(3'b000, 8'h00, 32'h1234, 32'h5678, 5'd12, 1'b1);
    tick();
    chk("nop_wr_en", {31'd0, mem_wr_en}, 32'd1);
    chk("nop_data", mem_wr_data, 32'd0);

    // divide issued with wr_en set must not forward while stalled
    drive(3'b011, 8'h1B, 32'd100, 32'd7, 5'd9, 1'b1);
    #1;
    chk("div_fwd_blocked", {31'd0, ex_rewrite_en}, 32'd0);
    do_div("divu_100_7", 8'h1B, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    do_div("div_m7_2", 8'h1A, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF);
    do_div("div_min_m1", 8'h1A, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'h0);
    do_div("divu_5_0", 8'h1B, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 32'd5);

    // flush at BUSY count 10
    drive(3'b011, 8'h1B, 32'd100, 32'd7, 5'd9, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    #1;
    chk("flush_stall_drop", {31'd0, stall_req}, 32'd0);
    tick();
    flush = 1'b0;
    nop();
    hilo_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_hilo_en === 1'b1) hilo_seen++;
    end
    chk("flush_no_hilo", hilo_seen, 0);
    chk("flush_stall_idle", {31'd0, stall_req}, 32'd0);

    // async reset mid-divide
    drive(3'b011, 8'h1B, 32'd100, 32'd7, 5'd9, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b1;
    #1;
    chk("rstmid_stall", {31'd0, stall_req}, 32'd0);
    chk("rstmid_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rstmid_hilo", {31'd0, mem_hilo_en}, 32'd0);
    nop();
    tick();
    reset = 1'b0;
    hilo_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_hilo_en === 1'b1) hilo_seen++;
    end
    chk("rstmid_no_hilo", hilo_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
